// File: rtl/seq_det_pkg.sv
// Shared encodings for the time-shared ones-modulo-3 detector and its controller.
package seq_det_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  typedef enum logic [1:0] {
    C0 = 2'd0,
    C1 = 2'd1,
    C2 = 2'd2
  } det_e;

  // A 0 holds the count; a 1 advances it, wrapping C2 back to C0.
  function automatic det_e det_next(input det_e s, input logic b);
    det_e n;
    if (!b) begin
      n = s;
    end else begin
      case (s)
        C0:      n = C1;
        C1:      n = C2;
        default: n = C0;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/ones_det_ctx.sv
// Ones-modulo-3 detector with a loadable state, so a saved context can be resumed.
module ones_det_ctx
  import seq_det_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] load_state,
  input  logic       bit_vld,
  input  logic       bit_in,
  output logic       hit,
  output logic [1:0] state_out
);

  det_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = det_e'(load_state);
    end else if (bit_vld) begin
      state_d = det_next(state_q, bit_in);
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= C0;
    end else begin
      state_q <= state_d;
    end
  end

  assign hit       = bit_vld & bit_in & (state_q == C2);
  assign state_out = state_q;

endmodule

// File: rtl/det_share_sched.sv
// Round-robin scheduler time-sharing one ones-modulo-3 detector among N requesters,
// keeping a per-requester detector context between words.
module det_share_sched
  import seq_det_pkg::*;
#(
  parameter  int N  = N_DEF,
  parameter  int W  = W_DEF,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int HW = $clog2(W + 1),
  localparam int CW = $clog2(W + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  data_i,
  input  logic [N-1:0]    ctx_clr,
  output logic [N-1:0]    gnt,
  output logic            busy,
  output logic            done,
  output logic [IW-1:0]   done_id,
  output logic [HW-1:0]   hit_cnt
);

  fsm_e            state_q, state_d;
  logic [W-1:0]    sh_q, sh_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   id_q, id_d;
  logic [IW-1:0]   last_q, last_d;
  logic [HW-1:0]   hit_q, hit_d;
  logic            clr_pend_q, clr_pend_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  det_e            ctx_q [N];
  det_e            ctx_d [N];

  logic            win_vld;
  logic [IW-1:0]   win;
  logic            det_load;
  logic [1:0]      det_load_state;
  logic            bit_vld;
  logic            det_hit;
  logic [1:0]      det_state;

  // Round-robin search starting one past the last grant.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int k = 1; k <= N; k++) begin
      if (!win_vld && req[(int'(last_q) + k) % N]) begin
        win_vld = 1'b1;
        win     = IW'((int'(last_q) + k) % N);
      end else begin
        win_vld = win_vld;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    sh_d           = sh_q;
    cnt_d          = cnt_q;
    id_d           = id_q;
    last_d         = last_q;
    hit_d          = hit_q;
    clr_pend_d     = clr_pend_q;
    gnt_d          = '0;
    busy_d         = busy_q;
    done_d         = 1'b0;
    det_load       = 1'b0;
    det_load_state = C0;
    bit_vld        = 1'b0;
    // Clears for requesters not in service take effect immediately.
    for (int i = 0; i < N; i++) begin
      ctx_d[i] = (ctx_clr[i] && !(busy_q && (id_q == IW'(i)))) ? C0 : ctx_q[i];
    end
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          sh_d           = data_i[int'(win)*W +: W];
          id_d           = win;
          last_d         = win;
          hit_d          = '0;
          cnt_d          = '0;
          clr_pend_d     = 1'b0;
          gnt_d[win]     = 1'b1;
          busy_d         = 1'b1;
          det_load       = 1'b1;
          det_load_state = ctx_clr[win] ? C0 : ctx_q[win];
          state_d        = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        bit_vld    = 1'b1;
        sh_d       = sh_q >> 1;
        hit_d      = hit_q + HW'(det_hit);
        cnt_d      = cnt_q + CW'(1);
        clr_pend_d = clr_pend_q | ctx_clr[id_q];
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        // A clear seen at any point during service overrides the save.
        ctx_d[id_q] = (clr_pend_q || ctx_clr[id_q]) ? C0 : det_e'(det_state);
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      cnt_q      <= '0;
      id_q       <= '0;
      last_q     <= IW'(N - 1);
      hit_q      <= '0;
      clr_pend_q <= 1'b0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < N; i++) begin
        ctx_q[i] <= C0;
      end
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      last_q     <= last_d;
      hit_q      <= hit_d;
      clr_pend_q <= clr_pend_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      for (int i = 0; i < N; i++) begin
        ctx_q[i] <= ctx_d[i];
      end
    end
  end

  ones_det_ctx u_det (
    .clk        (clk),
    .rst        (rst),
    .load       (det_load),
    .load_state (det_load_state),
    .bit_vld    (bit_vld),
    .bit_in     (sh_q[0]),
    .hit        (det_hit),
    .state_out  (det_state)
  );

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = id_q;
  assign hit_cnt = hit_q;

endmodule
